// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
package note_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_e;
    typedef struct packed {
        logic [7:0] period;
        logic [3:0] beats;
    } entry_t;
    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [3:0] END_BEATS = 4'd0;
endpackage

// File: rtl/note_seq_if.sv
// note_seq_if: control, song-table write and player-facing signals of the sequencer.
interface note_seq_if #(parameter int NUM_NOTES = 8, parameter int BEAT_W = 16);
    localparam int IW = $clog2(NUM_NOTES);
    logic              wr_en;
    logic [IW-1:0]     wr_addr;
    logic [7:0]        wr_period;
    logic [3:0]        wr_beats;
    logic              start;
    logic              stop;
    logic [BEAT_W-1:0] beat_len;
    logic [7:0]        period;
    logic              np_rst;
    logic              busy;
    logic              done;
    logic [IW-1:0]     note_idx;
    logic [1:0]        state;
    modport master (
        output wr_en, wr_addr, wr_period, wr_beats, start, stop, beat_len,
        input  period, np_rst, busy, done, note_idx, state
    );
    modport slave (
        input  wr_en, wr_addr, wr_period, wr_beats, start, stop, beat_len,
        output period, np_rst, busy, done, note_idx, state
    );
endinterface

// File: rtl/note_seq_mem.sv
// note_seq_mem: song table register file, cleared by reset, one write and one combinational read port.
module note_seq_mem
    import note_seq_pkg::*;
#(
    parameter int NUM_NOTES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_NOTES)-1:0] wr_addr_i,
    input  entry_t                       wr_data_i,
    input  logic [$clog2(NUM_NOTES)-1:0] rd_addr_i,
    output entry_t                       rd_data_o
);
    entry_t mem_q [NUM_NOTES];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NOTES; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end
    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/note_sequencer_rtl.sv
// note_sequencer_rtl: steps through the song table, driving the note player's period and reset.
module note_sequencer_rtl
    import note_seq_pkg::*;
#(
    parameter int NUM_NOTES = 8,
    parameter int BEAT_W    = 16
) (
    input logic       clk,
    input logic       rst,
    note_seq_if.slave bus
);
    localparam int IW = $clog2(NUM_NOTES);
    state_e            state_q;
    logic [IW-1:0]     note_idx_q;
    logic [7:0]        period_q;
    logic [3:0]        beats_left_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [BEAT_W-1:0] beat_end;
    logic              beat_wrap;
    entry_t            rd_entry;
    note_seq_mem #(.NUM_NOTES(NUM_NOTES)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i ({bus.wr_period, bus.wr_beats}),
        .rd_addr_i (note_idx_q),
        .rd_data_o (rd_entry)
    );
    // beat_len of 0 behaves as 1, so the beat ends when the counter sits at 0
    assign beat_end  = (bus.beat_len == '0) ? '0 : bus.beat_len - 1'b1;
    assign beat_wrap = beat_cnt_q == beat_end;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            note_idx_q   <= '0;
            period_q     <= '0;
            beats_left_q <= '0;
            beat_cnt_q   <= '0;
        end else if (bus.stop) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q    <= LOAD;
                    note_idx_q <= '0;
                end
                LOAD: if (rd_entry.beats == END_BEATS) begin
                    state_q <= DONE;
                end else begin
                    period_q     <= rd_entry.period;
                    beats_left_q <= rd_entry.beats;
                    beat_cnt_q   <= '0;
                    state_q      <= PLAY;
                end
                PLAY: begin
                    beat_cnt_q <= beat_wrap ? '0 : beat_cnt_q + 1'b1;
                    if (beat_wrap) beats_left_q <= beats_left_q - 1'b1;
                    if (beat_wrap && beats_left_q == 4'd1) begin
                        if (note_idx_q == IW'(NUM_NOTES - 1)) begin
                            state_q <= DONE;
                        end else begin
                            note_idx_q <= note_idx_q + 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.period   = (state_q == PLAY) ? period_q : NOTE_REST;
    assign bus.np_rst   = state_q != PLAY || period_q == NOTE_REST;
    assign bus.busy     = state_q == LOAD || state_q == PLAY;
    assign bus.done     = state_q == DONE;
    assign bus.note_idx = note_idx_q;
    assign bus.state    = state_q;
endmodule

// File: doc/note_sequencer_rtl.md
# note_sequencer_rtl

Sequences a stored song onto the single-note player datapath. The block holds an 8-entry song table; each entry is a note period plus a duration in beats. On `start` it steps through the table, drives the player's `period` input and player reset for each note, and times each note in beats of a programmable cycle length. It sits between the board-level control (buttons/switches) and the note player.

## Interface
Parameters:
- `NUM_NOTES`, default 8: song table depth; index width is `$clog2(NUM_NOTES)`, which is 3 at the default.
- `BEAT_W`, default 16: width of `beat_len` and of the internal beat counter.

Ports:
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `wr_en` input, 1 bit: write one song-table entry this cycle.
- `wr_addr` input, 3 bits: entry index for the write.
- `wr_period` input, 8 bits: note period for the write; 0 means a rest.
- `wr_beats` input, 4 bits: note duration in beats; 0 marks end of song.
- `start` input, 1 bit: begin playback from entry 0.
- `stop` input, 1 bit: abort playback.
- `beat_len` input, `BEAT_W` bits: cycles per beat; 0 is treated as 1.
- `period` output, 8 bits: period value for the note player.
- `np_rst` output, 1 bit: reset to the note player; high means the player is silent.
- `busy` output, 1 bit: high in LOAD and PLAY.
- `done` output, 1 bit: one-cycle pulse when the song ends normally.
- `note_idx` output, 3 bits: index of the entry currently being played.
- `state` output, 2 bits: FSM state encoding, for debug.

## Operation
- FSM states and encodings: IDLE=0, LOAD=1, PLAY=2, DONE=3.
- IDLE:
  - `start`=1 goes to LOAD with `note_idx`=0.
  - Otherwise the FSM stays in IDLE.
- LOAD (one cycle):
  - Reads `mem[note_idx]`.
  - If beats==0, goes to DONE.
  - Otherwise latches `period_r`=entry period and `beats_left`=entry beats, clears `beat_cnt`, and goes to PLAY.
- PLAY:
  - `beat_cnt` increments every cycle.
  - At `beat_cnt`==max(`beat_len`,1)-1, `beat_cnt` returns to 0 and `beats_left` decrements.
  - When that wrap occurs with `beats_left`==1:
    - If `note_idx`==NUM_NOTES-1, go to DONE.
    - Otherwise increment `note_idx` and go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `stop`=1 in LOAD, PLAY or DONE forces IDLE on the next edge. `done` is not pulsed, and `note_idx` is held.
- Output rules:
  - `np_rst` = (state != PLAY) or (`period_r`==0). Rests and note boundaries are therefore silent, and each note starts with a freshly reset waveform.
  - `period` = `period_r` while in PLAY, else 0.
- Song table:
  - Writes take effect on the next edge in any state.
  - A write to the entry currently playing does not affect the latched note; it takes effect the next time that entry is loaded.
- Simultaneous events:
  - `stop` and `start` together: `stop` wins.
  - `start` while `busy`: ignored.
  - A write and a LOAD read of the same address in the same cycle: LOAD sees the old value.
- `beat_len` is sampled every cycle. Changing it mid-note changes the current beat's end point; if `beat_cnt` has already passed the new end, the counter runs on until it wraps at 2^BEAT_W.

## Timing
- Reset values:
  - state=IDLE, `note_idx`=0, `period`=0, `np_rst`=1, `busy`=0, `done`=0.
  - All table entries cleared to period 0 and beats 0.
- Latency:
  - `start` sampled at edge 0 gives LOAD in cycle 1 and PLAY from cycle 2.
  - Each note occupies exactly beats × max(`beat_len`,1) PLAY cycles, followed by one LOAD cycle (`np_rst`=1).
  - After the last note, DONE lasts one cycle, then IDLE.
- Reset asserted mid-song returns all state to the reset values immediately (asynchronous) and clears the song table.

## Structure
- Package `note_seq_pkg` holds:
  - the state enum typedef with the encodings above;
  - an entry struct {period[7:0], beats[3:0]};
  - the constants `NOTE_REST`=0 and `END_BEATS`=0.
- One sub-module, `note_seq_mem`: the NUM_NOTES×12-bit register file with asynchronous clear, one write port and one combinational read port.
- The top level contains the FSM, `beat_cnt`, `beats_left`, `note_idx` and the output logic.

## Test plan
- Reset, then no stimulus: `np_rst`=1, `period`=0, `busy`=0, `state`=0 for 20 cycles.
- Write {period 10, beats 2} and {period 20, beats 1} to entries 0–1, entry 2 beats=0; `beat_len`=4; pulse `start`:
  - `period`=10 for cycles 2–9;
  - `np_rst`=1 in cycle 10;
  - `period`=20 for cycles 11–14;
  - `done` pulses in cycle 16 (LOAD of entry 2 in cycle 15).
- Entry 1 is a rest (period 0, beats 1): `np_rst` stays 1 and `period`=0 for its 4 PLAY cycles, then the song continues.
- All 8 entries have beats=1, `beat_len`=1: `note_idx` steps 0→7, and `done` follows entry 7 without wrapping to 0.
- `stop` in the 3rd PLAY cycle of a note: IDLE next cycle, `np_rst`=1, `done` never asserts; a later `start` replays from entry 0.
- `beat_len`=0 and one entry with beats=3: the note lasts exactly 3 PLAY cycles. Assert `rst` mid-note: outputs return to reset values and table reads return 0.
